// File: rtl/prog_loader_pkg.sv
// Shared state encoding and mode constants for the program loader.
package prog_loader_pkg;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_VRD   = 3'd3;
  localparam state_t ST_VCMP  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_VERIFY = 1'b1;

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector; pulse is high while sig_i is high and was low last cycle.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_c_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sig_i;
  end

  assign rise_c_o = sig_i & ~prev_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader / verifier: streams words into RAM or compares RAM against the stream,
// holding the CPU stalled until a clean session completes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CSUM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              programming_i,
  input  logic              mode_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [CSUM_W-1:0] checksum_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [CSUM_W-1:0]   checksum_q, checksum_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                prog_rise_c;
  logic [ADDR_W-1:0]   eff_last_c;

  edge_detect_rise u_prog_rise (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_i    (programming_i),
    .rise_c_o (prog_rise_c)
  );

  // Last address of the session: 0 or oversize length means full depth.
  always_comb begin
    if ((len_i == '0) || (32'(len_i) > DEPTH)) eff_last_c = ADDR_W'(DEPTH - 1);
    else                                       eff_last_c = ADDR_W'(len_i - (ADDR_W + 1)'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      word_q     <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      word_q     <= word_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  // Next state and datapath; dropping programming in an active state aborts to IDLE.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    word_d     = word_q;
    checksum_d = checksum_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (prog_rise_c) begin
          addr_d     = '0;
          last_d     = eff_last_c;
          checksum_d = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = '0;
          state_d    = (mode_i == MODE_VERIFY) ? ST_VRD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!programming_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (in_valid_i && in_ready_q) begin
          word_d     = in_data_i;
          checksum_d = checksum_q + CSUM_W'(in_data_i);
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!programming_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (addr_q == last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_VRD: begin
        if (!programming_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else if (in_valid_i && in_ready_q) begin
          word_d  = in_data_i;
          state_d = ST_VCMP;
        end
      end
      ST_VCMP: begin
        if (!programming_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          checksum_d = checksum_q + CSUM_W'(word_q);
          if ((mem_rdata_i != word_q) && !error_q) begin
            error_d    = 1'b1;
            err_addr_d = addr_q;
          end
          if (addr_q == last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_VRD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD) || (state_d == ST_VRD);
    mem_we_d   = (state_d == ST_WRITE);
    mem_re_d   = (state_d == ST_VRD);
    cpu_hold_d = !((state_d == ST_DONE) && !error_d);
  end

  assign in_ready_o  = in_ready_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = word_q;
  assign mem_we_o    = mem_we_q;
  assign mem_re_o    = mem_re_q;
  assign cpu_hold_o  = cpu_hold_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_addr_o  = err_addr_q;
  assign checksum_o  = checksum_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised program loader and run controller for the 8-bit CPU core.
- Accepts a program image byte-by-byte from the dedicated input pins using a valid/ready handshake, and writes it into the RAM.
- Can also read the RAM back and compare it against a second pass of the same stream, reporting mismatches.
- Holds the CPU in reset/stall until loading completes, then releases it; it sits between the pad ring and the RAM write port.

Parameters:
- DATA_W, 8: width of one RAM word / input byte.
- ADDR_W, 4: RAM address width; depth = 2**ADDR_W.
- CSUM_W, 8: width of the running checksum, modulo 2**CSUM_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- programming  in  1  level; high requests a load/verify session.
- mode  in  1  0 = load (write RAM), 1 = verify (read-compare); sampled when a session starts.
- len  in  ADDR_W+1  number of words to transfer; 0 means full depth; values above depth are clamped to depth.
- in_data  in  DATA_W  input word from pins.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write strobe, one cycle per word.
- mem_re  out  1  RAM read strobe.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re.
- cpu_hold  out  1  high keeps the CPU stalled.
- done  out  1  session finished cleanly; sticky until the next session or reset.
- error  out  1  verify mismatch; sticky until the next session or reset.
- err_addr  out  ADDR_W  address of the first mismatch.
- checksum  out  CSUM_W  running sum of accepted words.

Behaviour:
- Reset, asynchronous and active-low:
  - State goes to IDLE.
  - All outputs are 0, except cpu_hold, which is 1.
- States: IDLE, LOAD, WRITE, VRD, VCMP, DONE.
- IDLE:
  - On a rising edge of programming (registered previous value was 0, current is 1): latch mode, latch the effective length N, clear addr, checksum, done, error and err_addr.
  - Then go to LOAD if mode=0, or VRD if mode=1.
  - cpu_hold=1 from the first cycle of the session.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready: capture the word, checksum += word, go to WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle, with mem_addr=addr and mem_wdata equal to the captured word.
  - If addr == N-1 go to DONE; otherwise addr+1 and go to LOAD.
  - Throughput is one word per 2 cycles; in_ready is low during WRITE.
- VRD:
  - mem_re=1 and mem_addr=addr.
  - in_ready=1; the loader waits in VRD until in_valid, then captures the word and goes to VCMP.
  - mem_re is held each cycle while waiting.
- VCMP:
  - Compare mem_rdata with the captured word; checksum += word.
  - On mismatch with error still 0: set error=1 and err_addr=addr.
  - Later mismatches do not change err_addr; verification continues to the end.
  - Last word goes to DONE; otherwise addr+1 and go to VRD.
- DONE:
  - done=1 (set on DONE entry, even if error=1).
  - cpu_hold=0 when error=0; cpu_hold stays 1 when error=1.
  - Falling programming does not clear done.
  - A new rising edge of programming starts a new session.
- Abort: programming falling in any active state (LOAD/WRITE/VRD/VCMP):
  - Go to IDLE with done=0 and cpu_hold=1.
  - A write already in WRITE completes that cycle; no further memory access occurs.
- cpu_hold outside a session:
  - IDLE after reset: 1.
  - IDLE after a completed session: follows the DONE rule.
- Wrap and length:
  - addr never exceeds N-1, so there is no wrap.
  - len=0 or len > 2**ADDR_W gives N = 2**ADDR_W.
- Simultaneous events:
  - in_valid is ignored outside LOAD/VRD.
  - If programming falls in the same cycle as a handshake, the abort wins and the word is discarded (no write).
- Checksum: modulo 2**CSUM_W, zero-extended add of each accepted word.

Decomposition:
- Shared package `prog_loader_pkg`:
  - state enum (IDLE, LOAD, WRITE, VRD, VCMP, DONE).
  - mode constants MODE_LOAD=0, MODE_VERIFY=1.
- The control FSM and datapath live in one module.
- One natural sub-module: `edge_detect_rise`, the registered rising-edge detector for programming (reset value 0).

Test Plan:
- Reset, then programming=1, mode=0, len=4, stream 0x11, 0x22, 0x33, 0x44 with in_valid always 1:
  - mem_we pulses at addr 0..3 carrying those values.
  - done=1 and cpu_hold=0 in cycle 9 after start.
  - checksum=0xAA.
- Same as above with in_valid low for 3 cycles between words:
  - Writes occur only on handshakes.
  - Same final checksum 0xAA.
  - in_ready is never high during WRITE.
- Verify, mode=1, len=4, RAM model holding 0x11, 0x22, 0x99, 0x44, stream 0x11, 0x22, 0x33, 0x44:
  - error=1, err_addr=2, done=1, cpu_hold=1.
  - mem_we is never asserted.
- Full-depth load, len=0, ADDR_W=4:
  - Exactly 16 writes at addr 0..15.
  - done=1 after the 16th word.
- Abort: drop programming after 2 of 4 words are accepted:
  - State returns to IDLE, exactly 2 writes, done=0, cpu_hold=1.
  - A new rising edge restarts at addr 0 with checksum cleared.
- Assert rst_n=0 mid-WRITE:
  - mem_we drops immediately (asynchronously).
  - All outputs return to reset values (cpu_hold=1, done=0, error=0).
